// File: rtl/AXI_package.sv
`default_nettype none
// ============================================================================
//  Package     : AXI_package
//  Description : Register widths, command codes and status codes shared by
//                the regex coprocessor wrapper and anything that drives its
//                command/status register interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package AXI_package;

   localparam int REG_WIDTH    = 32;
   localparam int REG_WIDTH_64 = 64;

   // Command register encodings
   localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
   localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
   localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd2;
   localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd3;
   localparam logic [REG_WIDTH-1:0] CMD_RESTART            = 32'd4;
   localparam logic [REG_WIDTH-1:0] CMD_RESET              = 32'd5;

   // Status register encodings
   localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 32'd0;
   localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 32'd1;
   localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
   localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;
   localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = 32'd4;

endpackage
`default_nettype wire

// File: rtl/regex_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : regex_cmd_sequencer_pkg
//  Description : State encoding of the regex command sequencer, exported so
//                status-decode logic can name the states.
//  Revision    : 1.0 - initial release
// ============================================================================
package regex_cmd_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_START   = 3'd2,
      S_RUN     = 3'd3,
      S_READ_CC = 3'd4,
      S_RESTART = 3'd5,
      S_ABORT   = 3'd6,
      S_DONE    = 3'd7
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/regex_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : regex_cmd_sequencer
//  Description : Hardware initiator for the regex coprocessor. Accepts a job
//                descriptor and a stream of program words, loads them with
//                CMD_WRITE, starts the run, polls status, reads the elapsed
//                cycle counter, restarts the coprocessor and returns a result.
//  Ports       : clk/rst                      clock, sync active-high reset
//                job_*                        job descriptor handshake
//                word_*                       program word handshake
//                cmd/address/data_in_register registered command outputs
//                start/end_cc_pointer_register latched CC pointers
//                status_register/data_o_register coprocessor read-back
//                result_*                     result record handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module regex_cmd_sequencer
   import AXI_package::*;
   import regex_cmd_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH     = 9,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    job_valid,
   output logic                    job_ready,
   input  logic [ADDR_WIDTH:0]     job_words,
   input  logic [REG_WIDTH-1:0]    job_start_cc,
   input  logic [REG_WIDTH-1:0]    job_end_cc,
   input  logic                    word_valid,
   output logic                    word_ready,
   input  logic [REG_WIDTH_64-1:0] word_data,
   output logic [REG_WIDTH-1:0]    cmd_register,
   output logic [REG_WIDTH-1:0]    address_register,
   output logic [REG_WIDTH_64-1:0] data_in_register,
   output logic [REG_WIDTH-1:0]    start_cc_pointer_register,
   output logic [REG_WIDTH-1:0]    end_cc_pointer_register,
   input  logic [REG_WIDTH-1:0]    status_register,
   input  logic [REG_WIDTH_64-1:0] data_o_register,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic                    result_accept,
   output logic                    result_error,
   output logic                    result_timeout,
   output logic [REG_WIDTH-1:0]    result_cycles
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]       c_timeout   = TW'(TIMEOUT_CYCLES);
   localparam logic [ADDR_WIDTH:0] c_max_words = {1'b1, {ADDR_WIDTH{1'b0}}};

   seq_state_t state_q, state_d;
   logic [REG_WIDTH-1:0]    cmd_q, cmd_d, addr_q, addr_d;
   logic [REG_WIDTH_64-1:0] data_q, data_d;
   logic [REG_WIDTH-1:0]    scc_q, scc_d, ecc_q, ecc_d, cycles_q, cycles_d;
   logic [ADDR_WIDTH:0]     words_q, words_d, cnt_q, cnt_d;
   logic [TW-1:0]           tcnt_q, tcnt_d, w_tcnt_inc;
   logic job_ready_q, job_ready_d, word_ready_q, word_ready_d;
   logic rvalid_q, rvalid_d, accept_q, accept_d, error_q, error_d, tmo_q, tmo_d;
   logic w_job_fire, w_word_fire, w_tmo_hit, w_complete;
   logic w_unused_data_hi;

   // Only the low word of the read-back carries the elapsed-cycle count.
   assign w_unused_data_hi = ^data_o_register[REG_WIDTH_64-1:REG_WIDTH];

   assign w_job_fire  = job_valid  && job_ready_q;
   assign w_word_fire = word_valid && word_ready_q;
   assign w_tcnt_inc  = tcnt_q + 1'b1;
   assign w_tmo_hit   = (w_tcnt_inc == c_timeout);
   assign w_complete  = (status_register == STATUS_ACCEPTED) ||
                        (status_register == STATUS_REJECTED) ||
                        (status_register == STATUS_ERROR);

   always_comb begin
      state_d  = state_q;
      cmd_d    = CMD_NOP;
      addr_d   = addr_q;
      data_d   = data_q;
      scc_d    = scc_q;
      ecc_d    = ecc_q;
      words_d  = words_q;
      cnt_d    = cnt_q;
      tcnt_d   = tcnt_q;
      accept_d = accept_q;
      error_d  = error_q;
      tmo_d    = tmo_q;
      cycles_d = cycles_q;
      case (state_q)
         S_IDLE: begin
            if (w_job_fire) begin
               words_d  = (job_words > c_max_words) ? c_max_words : job_words;
               scc_d    = job_start_cc;
               ecc_d    = job_end_cc;
               cnt_d    = '0;
               tcnt_d   = '0;
               accept_d = 1'b0;
               error_d  = 1'b0;
               tmo_d    = 1'b0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            // word_ready is low once cnt_q reaches words_q, so the START
            // decision can never coincide with a pending write.
            if (cnt_q == words_q) begin
               cmd_d   = CMD_START;
               state_d = S_START;
            end else if (w_word_fire) begin
               cmd_d  = CMD_WRITE;
               addr_d = {{(REG_WIDTH-ADDR_WIDTH){1'b0}}, cnt_q[ADDR_WIDTH-1:0]};
               data_d = word_data;
               cnt_d  = cnt_q + 1'b1;
            end
         end
         S_START, S_RUN: begin
            tcnt_d = w_tcnt_inc;
            // Timeout wins over any status sampled in the same cycle.
            if (w_tmo_hit) begin
               cmd_d   = CMD_RESET;
               state_d = S_ABORT;
            end else if (state_q == S_START) begin
               if (status_register == STATUS_RUNNING) state_d = S_RUN;
               else                                   cmd_d   = CMD_START;
            end else if (w_complete) begin
               accept_d = (status_register == STATUS_ACCEPTED);
               error_d  = (status_register == STATUS_ERROR);
               cmd_d    = CMD_READ_ELAPSED_CLOCK;
               state_d  = S_READ_CC;
            end
         end
         S_READ_CC: begin
            cycles_d = data_o_register[REG_WIDTH-1:0];
            cmd_d    = CMD_RESTART;
            state_d  = S_RESTART;
         end
         S_RESTART: begin
            if (status_register == STATUS_IDLE) state_d = S_DONE;
            else                                cmd_d   = CMD_RESTART;
         end
         S_ABORT: begin
            accept_d = 1'b0;
            error_d  = 1'b1;
            tmo_d    = 1'b1;
            cycles_d = REG_WIDTH'(TIMEOUT_CYCLES);
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (result_ready && rvalid_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      job_ready_d  = (state_d == S_IDLE) && (status_register == STATUS_IDLE);
      word_ready_d = (state_d == S_LOAD) && (cnt_d < words_d);
      rvalid_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cmd_q        <= CMD_NOP;
         addr_q       <= '0;
         data_q       <= '0;
         scc_q        <= '0;
         ecc_q        <= '0;
         words_q      <= '0;
         cnt_q        <= '0;
         tcnt_q       <= '0;
         job_ready_q  <= 1'b0;
         word_ready_q <= 1'b0;
         rvalid_q     <= 1'b0;
         accept_q     <= 1'b0;
         error_q      <= 1'b0;
         tmo_q        <= 1'b0;
         cycles_q     <= '0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         scc_q        <= scc_d;
         ecc_q        <= ecc_d;
         words_q      <= words_d;
         cnt_q        <= cnt_d;
         tcnt_q       <= tcnt_d;
         job_ready_q  <= job_ready_d;
         word_ready_q <= word_ready_d;
         rvalid_q     <= rvalid_d;
         accept_q     <= accept_d;
         error_q      <= error_d;
         tmo_q        <= tmo_d;
         cycles_q     <= cycles_d;
      end
   end

   assign job_ready                 = job_ready_q;
   assign word_ready                = word_ready_q;
   assign cmd_register              = cmd_q;
   assign address_register          = addr_q;
   assign data_in_register          = data_q;
   assign start_cc_pointer_register = scc_q;
   assign end_cc_pointer_register   = ecc_q;
   assign result_valid              = rvalid_q;
   assign result_accept             = accept_q;
   assign result_error              = error_q;
   assign result_timeout            = tmo_q;
   assign result_cycles             = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_regex_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regex_cmd_sequencer
//  Description : Self-checking bench for regex_cmd_sequencer with a
//                behavioural coprocessor model and a command log checked
//                against the expected job command sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regex_cmd_sequencer;
   import AXI_package::*;

   localparam int AW = 9;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic job_valid = 1'b0, job_ready, word_valid = 1'b0, word_ready;
   logic [AW:0] job_words = '0;
   logic [REG_WIDTH-1:0] job_start_cc = '0, job_end_cc = '0;
   logic [REG_WIDTH_64-1:0] word_data = '0, data_in_register, data_o_register;
   logic [REG_WIDTH-1:0] cmd_register, address_register, status_register;
   logic [REG_WIDTH-1:0] start_cc_pointer_register, end_cc_pointer_register, result_cycles;
   logic result_valid, result_ready = 1'b0, result_accept, result_error, result_timeout;

   always #5 clk = ~clk;

   regex_cmd_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_words(job_words),
      .job_start_cc(job_start_cc), .job_end_cc(job_end_cc),
      .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
      .cmd_register(cmd_register), .address_register(address_register),
      .data_in_register(data_in_register),
      .start_cc_pointer_register(start_cc_pointer_register),
      .end_cc_pointer_register(end_cc_pointer_register),
      .status_register(status_register), .data_o_register(data_o_register),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_accept(result_accept), .result_error(result_error),
      .result_timeout(result_timeout), .result_cycles(result_cycles)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- coprocessor model ----------------
   logic [REG_WIDTH-1:0] m_status = STATUS_IDLE;
   logic [REG_WIDTH-1:0] m_elapsed = '0;
   logic [REG_WIDTH-1:0] cfg_final = STATUS_ACCEPTED;
   int   m_rem = 0;
   int   cfg_run_len = 1;
   bit   m_hang = 1'b0;
   bit   m_busy_force = 1'b0;
   logic [63:0] m_mem [0:511];

   assign status_register = m_busy_force ? STATUS_RUNNING : m_status;
   assign data_o_register = (cmd_register == CMD_READ_ELAPSED_CLOCK) ?
                            {32'hCAFE_F00D, m_elapsed} : 64'hFFFF_FFFF_FFFF_FFFF;

   always @(posedge clk) begin
      if (cmd_register == CMD_WRITE) m_mem[address_register[AW-1:0]] <= data_in_register;
      if (cmd_register == CMD_START && m_status == STATUS_IDLE) begin
         m_status  <= STATUS_RUNNING;
         m_elapsed <= '0;
         m_rem     <= cfg_run_len;
      end else if (cmd_register == CMD_RESTART || cmd_register == CMD_RESET) begin
         m_status <= STATUS_IDLE;
      end else if (m_status == STATUS_RUNNING) begin
         m_elapsed <= m_elapsed + 1;
         m_rem     <= m_rem - 1;
         if (!m_hang && m_rem == 1) m_status <= cfg_final;
      end
   end

   // ---------------- command log ----------------
   typedef struct {
      logic [31:0] cmd;
      logic [31:0] addr;
      logic [63:0] data;
      int          cyc;
   } ev_t;
   ev_t  log_q[$];
   int   cyc = 0;
   logic [31:0] last_cmd = '0;
   int   last_cyc = -10;

   always @(posedge clk) cyc <= cyc + 1;

   // Held START/RESTART commands collapse to one entry; everything else logs per cycle.
   always @(negedge clk) begin
      if (!rst && cmd_register != CMD_NOP) begin
         if (!((cmd_register == CMD_START || cmd_register == CMD_RESTART) &&
               log_q.size() > 0 && last_cmd == cmd_register && last_cyc == cyc - 1)) begin
            ev_t e;
            e.cmd = cmd_register; e.addr = address_register;
            e.data = data_in_register; e.cyc = cyc;
            log_q.push_back(e);
         end
         last_cmd = cmd_register;
         last_cyc = cyc;
      end
   end

   // ---------------- job driver and checker ----------------
   // mode: 0 accepted, 1 rejected, 2 error, 3 coprocessor hangs (timeout)
   task automatic run_job(input int words, input int mode, input int run_len,
                          input int gap_lo, input int gap_hi, input int hold);
      logic [63:0] prog[$];
      int gaps[$];
      int nw, t, t_job, exp_c, s_cyc, exp_n;
      logic [31:0] scc, ecc, exp_cycles;
      nw = (words > 512) ? 512 : words;
      for (int i = 0; i < nw; i++) begin
         prog.push_back({$urandom(), $urandom()});
         gaps.push_back($urandom_range(gap_hi, gap_lo));
      end
      scc = $urandom(); ecc = $urandom();
      cfg_run_len = run_len;
      m_hang      = (mode == 3);
      cfg_final   = (mode == 0) ? STATUS_ACCEPTED : (mode == 1) ? STATUS_REJECTED : STATUS_ERROR;
      exp_cycles  = (mode == 3) ? TO : run_len;
      log_q.delete();

      job_valid = 1'b1; job_words = words[AW:0]; job_start_cc = scc; job_end_cc = ecc;
      t = 0;
      while (!job_ready && t < 100) begin @(negedge clk); t++; end
      if (t == 100) check("job_ready_wait", job_ready, 1);
      t_job = cyc;
      @(negedge clk);
      job_valid = 1'b0;

      for (int i = 0; i < nw; i++) begin
         word_valid = 1'b0;
         repeat (gaps[i]) @(negedge clk);
         word_valid = 1'b1; word_data = prog[i];
         t = 0;
         while (!word_ready && t < 50) begin @(negedge clk); t++; end
         if (t == 50) check("word_ready_wait", word_ready, 1);
         @(negedge clk);
      end
      word_valid = 1'b0;

      t = 0;
      while (!result_valid && t < 300) begin @(negedge clk); t++; end
      check("result_valid_wait", result_valid, 1);
      check("ptr_start", start_cc_pointer_register, scc);
      check("ptr_end", end_cc_pointer_register, ecc);
      for (int h = 0; h <= hold; h++) begin
         check("res_valid_hold", result_valid, 1);
         check("res_accept", result_accept, mode == 0);
         check("res_error", result_error, mode >= 2);
         check("res_timeout", result_timeout, mode == 3);
         check("res_cycles", result_cycles, exp_cycles);
         if (h < hold) @(negedge clk);
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("res_valid_drop", result_valid, 0);

      exp_n = nw + ((mode == 3) ? 2 : 3);
      check("log_len", log_q.size(), exp_n);
      if (log_q.size() == exp_n) begin
         exp_c = t_job + 2;
         for (int k = 0; k < nw; k++) begin
            exp_c += gaps[k];
            check("wr_cmd", log_q[k].cmd, CMD_WRITE);
            check("wr_addr", log_q[k].addr, k);
            check("wr_data", log_q[k].data, prog[k]);
            check("wr_cycle", log_q[k].cyc, exp_c);
            exp_c++;
         end
         check("start_cmd", log_q[nw].cmd, CMD_START);
         check("start_cycle", log_q[nw].cyc, exp_c);
         s_cyc = exp_c;
         if (mode == 3) begin
            check("reset_cmd", log_q[nw+1].cmd, CMD_RESET);
            check("reset_cycle", log_q[nw+1].cyc, s_cyc + TO);
         end else begin
            check("read_cmd", log_q[nw+1].cmd, CMD_READ_ELAPSED_CLOCK);
            check("read_cycle", log_q[nw+1].cyc, s_cyc + 2 + run_len);
            check("restart_cmd", log_q[nw+2].cmd, CMD_RESTART);
            check("restart_cycle", log_q[nw+2].cyc, s_cyc + 3 + run_len);
         end
      end
      if (nw > 0) check("mem_last", m_mem[nw-1], prog[nw-1]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      repeat (3) @(negedge clk);
      check("rst_cmd", cmd_register, CMD_NOP);
      check("rst_addr", address_register, 0);
      check("rst_data", data_in_register, 0);
      check("rst_scc", start_cc_pointer_register, 0);
      check("rst_ecc", end_cc_pointer_register, 0);
      check("rst_job_ready", job_ready, 0);
      check("rst_word_ready", word_ready, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_accept", result_accept, 0);
      check("rst_error", result_error, 0);
      check("rst_timeout", result_timeout, 0);
      check("rst_cycles", result_cycles, 0);
      rst = 1'b0;
      @(negedge clk);

      run_job(3, 0, 7, 0, 0, 0);    // back-to-back load, accepted
      run_job(3, 0, 5, 2, 2, 1);    // 2-cycle stalls between words
      run_job(0, 1, 4, 0, 0, 0);    // no load, rejected
      run_job(2, 2, 3, 0, 1, 5);    // error, result held 5 cycles
      run_job(1, 3, 1, 0, 0, 2);    // coprocessor hangs -> timeout

      // Reset in the middle of a 4-word load
      job_valid = 1'b1; job_words = 11'd4;
      t = 0;
      while (!job_ready && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      job_valid = 1'b0;
      word_valid = 1'b1; word_data = 64'h1111;
      @(negedge clk);
      word_data = 64'h2222;
      @(negedge clk);
      word_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("midrst_cmd", cmd_register, CMD_NOP);
      check("midrst_word_ready", word_ready, 0);
      check("midrst_job_ready", job_ready, 0);
      rst = 1'b0; m_busy_force = 1'b1;
      @(negedge clk);
      check("busy_job_ready", job_ready, 0);
      m_busy_force = 1'b0;
      @(negedge clk);
      check("idle_job_ready", job_ready, 1);
      run_job(4, 0, 6, 0, 1, 0);    // reload starts from address 0

      run_job(1023, 0, 2, 0, 0, 0); // word count saturates at 2**ADDR_WIDTH

      for (int j = 0; j < 15; j++)
         run_job($urandom_range(6, 0), $urandom_range(3, 0), $urandom_range(8, 1),
                 0, $urandom_range(2, 0), $urandom_range(3, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regex_cmd_sequencer.md
# regex_cmd_sequencer

Hardware initiator for the regex coprocessor command/status register interface: it drives the same registers the host writes (command, address, data, CC pointers) and reads back status and data. It accepts one job descriptor plus a stream of 64-bit program words, loads them into coprocessor memory with CMD_WRITE, issues CMD_START, polls status, reads the elapsed-cycle counter, restarts the coprocessor to idle and returns one result record. It sits between an on-FPGA job source (FIFO or bridge) and the coprocessor wrapper, replacing the software driver loop.

## Interface
- ADDR_WIDTH, 9: coprocessor memory address width; job_words is ADDR_WIDTH+1 bits.
- TIMEOUT_CYCLES, 2**20: maximum cycles in S_START plus S_RUN before abort.
- clk  in  1  clock; everything on posedge.
- rst  in  1  synchronous, active-high reset.
- job_valid / job_ready  in/out  1  job handshake; transfer when both high.
- job_words  in  ADDR_WIDTH+1  program words to load; 0 = skip load.
- job_start_cc, job_end_cc  in  REG_WIDTH  CC pointers for the run.
- word_valid / word_ready  in/out  1  program word handshake.
- word_data  in  REG_WIDTH_64  program word.
- cmd_register  out  REG_WIDTH  command to coprocessor; registered.
- address_register  out  REG_WIDTH  write address, zero-extended; registered.
- data_in_register  out  REG_WIDTH_64  write data; registered.
- start_cc_pointer_register, end_cc_pointer_register  out  REG_WIDTH  latched job pointers.
- status_register  in  REG_WIDTH  coprocessor status.
- data_o_register  in  REG_WIDTH_64  coprocessor read data.
- result_valid / result_ready  out/in  1  result handshake.
- result_accept, result_error, result_timeout  out  1  outcome flags.
- result_cycles  out  REG_WIDTH  elapsed cycles reported by coprocessor, or TIMEOUT_CYCLES on timeout.

## Operation
- Reset: state S_IDLE, cmd_register=CMD_NOP, address/data/pointers/result outputs 0, job_ready=0, word_ready=0, result_valid=0.
- S_IDLE: job_ready=1 only while status_register==STATUS_IDLE. On transfer: latch job_words (values > 2**ADDR_WIDTH saturate to 2**ADDR_WIDTH), latch pointers, clear word counter, clear timeout counter; go to S_LOAD.
- S_LOAD: word_ready=1 while counter<words. On word handshake, next cycle presents cmd=CMD_WRITE, address=counter, data=word_data, and the counter increments. Without a handshake, next cycle presents CMD_NOP; stalls insert NOPs and never repeat a write. When counter==words, present CMD_START next and go to S_START.
- S_START: hold CMD_START until status_register==STATUS_RUNNING is sampled, then present CMD_NOP and go to S_RUN.
- S_RUN: when status ∈ {ACCEPTED, REJECTED, ERROR} is sampled, latch accept=(ACCEPTED), error=(ERROR), present CMD_READ_ELAPSED_CLOCK, and go to S_READ_CC.
- S_READ_CC: one cycle. Capture data_o_register[REG_WIDTH-1:0] into result_cycles, present CMD_RESTART, and go to S_RESTART.
- S_RESTART: hold CMD_RESTART until STATUS_IDLE is sampled, then present CMD_NOP and go to S_DONE.
- S_DONE: result_valid=1 with stable flags and cycles until result_ready, then go to S_IDLE.
- Timeout: the counter increments every cycle in S_START and S_RUN. On reaching TIMEOUT_CYCLES, present CMD_RESET for exactly one cycle (S_ABORT), then CMD_NOP, then go to S_DONE with timeout=1, error=1, accept=0. Coprocessor memory contents are undefined after an abort; the next job must reload.
- Timeout has priority over a completion status sampled in the same cycle.
- rst in any state returns to reset values immediately. A half-loaded program is abandoned and no command is issued on the reset cycle.

## Timing
- All outputs are registered. A command takes effect in the coprocessor during the cycle it is presented.
- Load throughput: 1 word/cycle with word_valid held high. The write for handshake at cycle t is presented at t+1.
- Job handshake at cycle t → first CMD_WRITE at t+2 at the earliest; with job_words=0, CMD_START at t+2.
- result_valid rises 2 cycles after the completion status is sampled plus the restart-to-idle latency (1 cycle for the wrapper).
- status_register is sampled only in the states listed; its value elsewhere is ignored.

## Structure
- CMD_*, STATUS_*, REG_WIDTH and REG_WIDTH_64 come from AXI_package.
- Add a seq_state_t enum (S_IDLE, S_LOAD, S_START, S_RUN, S_READ_CC, S_RESTART, S_ABORT, S_DONE) to the package for the status-decode bench.
- Single flat module; no sub-module. The timeout counter is inline with width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Job words=3, words A,B,C streamed back to back, wrapper model accepts → WRITE@0,1,2 on consecutive cycles, then START; result accept=1, error=0, cycles equal the model's counter value (e.g. 57).
- Same job with word_valid low for 2 cycles between words → exactly 3 writes, 2 NOP gaps, addresses 0,1,2, no duplicates.
- words=0 → no CMD_WRITE; CMD_START is the first non-NOP command; REJECTED model → accept=0, error=0.
- Model returns STATUS_ERROR → error=1, CMD_READ_ELAPSED_CLOCK then CMD_RESTART issued, result_valid held 5 cycles until result_ready.
- TIMEOUT_CYCLES=16, model stays RUNNING → single-cycle CMD_RESET at cycle 16 of S_START+S_RUN; result timeout=1, cycles=16.
- rst pulsed mid-load after 2 of 4 words → cmd=CMD_NOP, job_ready follows status, next job loads from address 0.
